// File: rtl/act_stream_lut.sv
// -----------------------------------------------------------------------------
// act_stream_lut
//   Streaming activation unit: tanh, sigmoid (derived from the tanh table),
//   ReLU and bypass, selected per beat, behind a 2-stage valid/ready pipeline.
//   The channel tag rides along with each beat and is returned unchanged.
//
//   S1 : clamp the (possibly halved) input to the table range, register the
//        table index, mode, raw sample and tag.
//   S2 : table read and post-processing into the output register.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   input accepted when in_valid && in_ready
//   in_data    signed sample, IN_FRAC fraction bits
//   in_mode    0 tanh, 1 sigmoid, 2 ReLU, 3 bypass (sampled with the beat)
//   in_tag     sideband channel id
//   out_valid  output beat valid
//   out_ready  downstream accepts
//   out_data   activation result, Q1.(DATA_W-1)
//   out_tag    tag of the output beat
//
// Optional build macro ACT_LUT_SAT_CNT_EN adds:
//   sat_clr    synchronous clear of sat_count (wins over an increment)
//   sat_count  saturating count of delivered tanh/sigmoid beats whose table
//              index was clamped
//
// Table contents: the tanh image (entry LUT_HALF = tanh(0), one entry per
// input LSB, values truncated toward zero) is built at elaboration time by
// tanh_table(). LUT_FILE names that same image for flows that keep the
// hex file alongside the design.
// -----------------------------------------------------------------------------
module act_stream_lut #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned IN_FRAC  = 3,
   parameter int unsigned LUT_HALF = 48,
   parameter              LUT_FILE = "tanh_lut.hex",
   parameter int unsigned TAG_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_mode,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag
`ifdef ACT_LUT_SAT_CNT_EN
   ,
   input  logic              sat_clr,
   output logic [15:0]       sat_count
`endif
);

   typedef enum logic [1:0] {
      MODE_TANH    = 2'd0,
      MODE_SIGMOID = 2'd1,
      MODE_RELU    = 2'd2,
      MODE_BYPASS  = 2'd3
   } mode_e;

   localparam int unsigned DEPTH   = 2 * LUT_HALF;
   localparam int unsigned IDX_W   = $clog2(DEPTH);
   localparam int          HALF    = 1 << (DATA_W - 1);
   localparam int          MAX_POS = HALF - 1;
   localparam int          RELU_SH = int'(DATA_W) - 1 - int'(IN_FRAC);

   typedef logic [DEPTH*DATA_W-1:0] lut_t;

   // tanh(k / 2^IN_FRAC) in Q1.(DATA_W-1), truncated toward zero. Uses
   // y = exp(-2|x|) (2^-30 fixed point) and tanh|x| = (1-y)/(1+y).
   function automatic lut_t tanh_table();
      lut_t   tbl;
      longint one, r, term, y, v;
      tbl  = '0;
      one  = longint'(1) << 30;
      r    = one;
      term = one;
      // r = exp(-2 / 2^IN_FRAC) by Taylor series
      for (int n = 1; n < 40; n++) begin
         term = (term * 2) / ((longint'(1) << IN_FRAC) * longint'(n));
         r    = (n % 2 == 1) ? r - term : r + term;
      end
      y = one;
      for (int k = 0; k <= int'(LUT_HALF); k++) begin
         v = ((longint'(1) << (DATA_W - 1)) * (one - y)) / (one + y);
         if (k < int'(LUT_HALF))
            tbl[(int'(LUT_HALF) + k) * int'(DATA_W) +: DATA_W] = DATA_W'(v);
         if (k > 0)
            tbl[(int'(LUT_HALF) - k) * int'(DATA_W) +: DATA_W] = DATA_W'(-v);
         y = (y * r) >>> 30;
      end
      return tbl;
   endfunction

   localparam lut_t LUT = tanh_table();

   logic [DATA_W-1:0] rom [DEPTH];
   for (genvar i = 0; i < int'(DEPTH); i++) begin : g_rom
      assign rom[i] = LUT[i*DATA_W +: DATA_W];
   end

   // ---------------------------------------------------------------- handshake
   logic s1_valid_q, out_valid_q;
   logic s1_adv, s2_adv;

   assign s2_adv   = !out_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv && !rst;

   // ---------------------------------------------------------------- stage 1
   int               xs, xc;
   logic [IDX_W-1:0] idx_d, idx_q;
   mode_e            mode_q;
   logic [DATA_W-1:0] x_q;
   logic [TAG_W-1:0]  tag_q;

   // NOTE: every always_comb output gets a value before any branch, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      xs = int'($signed(in_data));
      if (mode_e'(in_mode) == MODE_SIGMOID) xs = xs >>> 1;
      xc = xs;
      if (xs >= int'(LUT_HALF))       xc = int'(LUT_HALF) - 1;
      else if (xs < -int'(LUT_HALF))  xc = -int'(LUT_HALF);
      idx_d = IDX_W'(xc + int'(LUT_HALF));
   end

   // NOTE: the payload registers carry no reset; the valid bits alone decide
   // whether their contents mean anything, so resetting them buys nothing.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         idx_q  <= idx_d;
         mode_q <= mode_e'(in_mode);
         x_q    <= in_data;
         tag_q  <= in_tag;
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [DATA_W-1:0] lut_word, out_data_d, out_data_q;
   logic [TAG_W-1:0]  out_tag_q;
   int                t_int, x_int;

   always_comb begin
      lut_word   = rom[idx_q];
      t_int      = int'($signed(lut_word));
      x_int      = int'($signed(x_q));
      out_data_d = x_q;
      case (mode_q)
         MODE_TANH:    out_data_d = lut_word;
         // (t + 2^(DATA_W-1)) >> 1, never negative so the shift is exact
         MODE_SIGMOID: out_data_d = DATA_W'((t_int + HALF) >>> 1);
         MODE_RELU: begin
            if (x_int < 0)                         out_data_d = '0;
            else if (x_int > (MAX_POS >>> RELU_SH)) out_data_d = DATA_W'(MAX_POS);
            else                                   out_data_d = DATA_W'(x_int <<< RELU_SH);
         end
         default:      out_data_d = x_q;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
      end else begin
         if (s1_adv) s1_valid_q  <= in_valid;
         if (s2_adv) out_valid_q <= s1_valid_q;
         // Output payload only moves with a real beat, so it holds under stall.
         if (s2_adv && s1_valid_q) begin
            out_data_q <= out_data_d;
            out_tag_q  <= tag_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;

`ifdef ACT_LUT_SAT_CNT_EN
   // ---------------------------------------------------------- clamp counter
   logic        clamp_q, out_sat_q;
   logic [15:0] sat_cnt_q;

   always_ff @(posedge clk) begin
      if (in_valid && in_ready)
         clamp_q <= (xs >= int'(LUT_HALF)) || (xs < -int'(LUT_HALF));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_sat_q <= 1'b0;
      end else if (s2_adv && s1_valid_q) begin
         out_sat_q <= clamp_q && ((mode_q == MODE_TANH) || (mode_q == MODE_SIGMOID));
      end
   end

   always_ff @(posedge clk) begin
      if (rst || sat_clr)
         sat_cnt_q <= '0;
      else if (out_valid_q && out_ready && out_sat_q && (sat_cnt_q != 16'hFFFF))
         sat_cnt_q <= sat_cnt_q + 16'd1;
   end

   assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_act_stream_lut.sv
// -----------------------------------------------------------------------------
// tb_act_stream_lut
//   Directed bench for act_stream_lut with default parameters (DATA_W=8,
//   IN_FRAC=3, LUT_HALF=48, TAG_W=4). Expected codes are hand-computed:
//   tanh(k/8)*128 truncated toward zero, sigmoid = (t+128)>>1, ReLU = x<<4
//   saturated at 0x7F.
// -----------------------------------------------------------------------------
module tb_act_stream_lut;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [1:0] in_mode;
   logic [3:0] in_tag;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] out_tag;
`ifdef ACT_LUT_SAT_CNT_EN
   logic        sat_clr;
   logic [15:0] sat_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   act_stream_lut dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
`ifdef ACT_LUT_SAT_CNT_EN
      ,
      .sat_clr   (sat_clr),
      .sat_count (sat_count)
`endif
   );

   localparam logic [1:0] M_TANH = 2'd0, M_SIG = 2'd1, M_RELU = 2'd2, M_BYP = 2'd3;

   // Stimulus table for run_stream and the per-cycle observations it records.
   logic [7:0] drv_d [16];
   logic [1:0] drv_m [16];
   logic [3:0] drv_t [16];
   logic [7:0] exp_d [16];
   logic       obs_v [16];
   logic [7:0] obs_d [16];
   logic [3:0] obs_t [16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int i, input logic [1:0] m, input logic [7:0] d,
                           input logic [3:0] t, input logic [7:0] e);
      drv_m[i] = m;
      drv_d[i] = d;
      drv_t[i] = t;
      exp_d[i] = e;
   endtask

   // Drives n back-to-back beats with out_ready=1 and records the output for
   // n+2 cycles: obs[j+1] is where beat j must appear.
   task automatic run_stream(input int n);
      out_ready = 1'b1;
      for (int c = 0; c < n + 2; c++) begin
         in_valid = (c < n);
         if (c < n) begin
            in_data = drv_d[c];
            in_mode = drv_m[c];
            in_tag  = drv_t[c];
         end
         tick();
         obs_v[c] = out_valid;
         obs_d[c] = out_data;
         obs_t[c] = out_tag;
      end
      in_valid = 1'b0;
   endtask

   task automatic check_stream(input string name, input int n);
      checks++;
      if (obs_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL %s early: out_valid=%b one cycle after accept, want 0", name, obs_v[0]);
      end
      for (int j = 0; j < n; j++) begin
         checks++;
         if (obs_v[j+1] !== 1'b1 || obs_d[j+1] !== exp_d[j] || obs_t[j+1] !== drv_t[j]) begin
            errors++;
            $display("FAIL %s beat %0d: valid=%b data=%h tag=%h, want valid=1 data=%h tag=%h",
                     name, j, obs_v[j+1], obs_d[j+1], obs_t[j+1], exp_d[j], drv_t[j]);
         end
      end
      checks++;
      if (obs_v[n+1] !== 1'b0) begin
         errors++;
         $display("FAIL %s tail: out_valid=%b after last beat, want 0", name, obs_v[n+1]);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h55;
      in_mode   = M_BYP;
      in_tag    = 4'h7;
      out_ready = 1'b1;
`ifdef ACT_LUT_SAT_CNT_EN
      sat_clr   = 1'b0;
`endif
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_tag !== 4'h0) begin
         errors++;
         $display("FAIL reset outputs: valid=%b data=%h tag=%h, want 0/00/0", out_valid, out_data, out_tag);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset in_ready: got %b, want 0", in_ready);
      end
`ifdef ACT_LUT_SAT_CNT_EN
      checks++;
      if (sat_count !== 16'd0) begin
         errors++;
         $display("FAIL reset sat_count: got %0d, want 0", sat_count);
      end
`endif
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release in_ready: got %b, want 1", in_ready);
      end
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset leak: out_valid=%b after release, want 0", out_valid);
      end
   endtask

   task automatic test_tanh();
      set_beat(0, M_TANH, 8'h00, 4'h1, 8'h00);
      set_beat(1, M_TANH, 8'h01, 4'h2, 8'h0F);
      set_beat(2, M_TANH, 8'h9C, 4'h3, 8'h81);  // -100
      set_beat(3, M_TANH, 8'h64, 4'h4, 8'h7F);  // 100
      set_beat(4, M_TANH, 8'h08, 4'h5, 8'h61);  // tanh(1.0)
      set_beat(5, M_TANH, 8'hF8, 4'h6, 8'h9F);  // tanh(-1.0)
      set_beat(6, M_TANH, 8'hFF, 4'h7, 8'hF1);  // tanh(-0.125)
      run_stream(7);
      check_stream("tanh", 7);
   endtask

   task automatic test_sigmoid();
      set_beat(0, M_SIG, 8'h00, 4'h8, 8'h40);
      set_beat(1, M_SIG, 8'h02, 4'h9, 8'h47);
      set_beat(2, M_SIG, 8'h10, 4'hA, 8'h70);   // xs=8
      set_beat(3, M_SIG, 8'hFD, 4'hB, 8'h30);   // -3 >>> 1 = -2
      set_beat(4, M_SIG, 8'h7F, 4'hC, 8'h7F);
      set_beat(5, M_SIG, 8'h80, 4'hD, 8'h00);
      run_stream(6);
      check_stream("sigmoid", 6);
   endtask

   task automatic test_relu_bypass();
      set_beat(0, M_RELU, 8'hFB, 4'h1, 8'h00);  // -5
      set_beat(1, M_RELU, 8'h03, 4'h2, 8'h30);
      set_beat(2, M_RELU, 8'h0A, 4'h3, 8'h7F);
      set_beat(3, M_RELU, 8'h07, 4'h4, 8'h70);
      set_beat(4, M_RELU, 8'h08, 4'h5, 8'h7F);
      set_beat(5, M_BYP,  8'hA5, 4'h6, 8'hA5);
      set_beat(6, M_BYP,  8'h80, 4'h7, 8'h80);
      set_beat(7, M_TANH, 8'h01, 4'h8, 8'h0F);  // mode switch back-to-back
      set_beat(8, M_BYP,  8'h7F, 4'h9, 8'h7F);
      run_stream(9);
      check_stream("relu_bypass", 9);
   endtask

   task automatic test_boundary();
      set_beat(0, M_TANH, 8'h2F, 4'h1, 8'h7F);  // 47 -> idx 95
      set_beat(1, M_TANH, 8'h30, 4'h2, 8'h7F);  // 48 clamped to idx 95
      set_beat(2, M_TANH, 8'hD0, 4'h3, 8'h81);  // -48 -> idx 0
      set_beat(3, M_TANH, 8'hCF, 4'h4, 8'h81);  // -49 clamped to idx 0
      set_beat(4, M_TANH, 8'h7F, 4'h5, 8'h7F);
      set_beat(5, M_TANH, 8'h80, 4'h6, 8'h81);
      run_stream(6);
      check_stream("boundary", 6);
   endtask

   task automatic test_backpressure();
      logic [31:0] opat;
      logic [15:0] vpat;
      int          sent, rcv, cyc;
      logic        prev_stall, exp_rdy;
      logic [7:0]  prev_d;
      logic [3:0]  prev_t;
      opat = 32'b1011_0001_1100_0101_1000_1101_0011_0001;
      vpat = 16'b1110_1111_0111_1011;
      set_beat(0, M_TANH, 8'h01, 4'h5, 8'h0F);
      set_beat(1, M_SIG,  8'h02, 4'hC, 8'h47);
      set_beat(2, M_RELU, 8'h03, 4'h3, 8'h30);
      set_beat(3, M_BYP,  8'hA5, 4'hA, 8'hA5);
      set_beat(4, M_TANH, 8'h08, 4'h1, 8'h61);
      set_beat(5, M_SIG,  8'hFD, 4'hE, 8'h30);
      set_beat(6, M_RELU, 8'h0A, 4'h7, 8'h7F);
      set_beat(7, M_BYP,  8'h3C, 4'h0, 8'h3C);
      sent = 0;
      rcv  = 0;
      cyc  = 0;
      prev_stall = 1'b0;
      prev_d = 8'h00;
      prev_t = 4'h0;
      while (rcv < 8 && cyc < 200) begin
         out_ready = opat[cyc % 32];
         in_valid  = (sent < 8) && vpat[cyc % 16];
         if (sent < 8) begin
            in_data = drv_d[sent];
            in_mode = drv_m[sent];
            in_tag  = drv_t[sent];
         end
         #1;
         // Two beats in flight means both stages hold data.
         exp_rdy = !((sent - rcv) == 2 && !out_ready);
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL bp in_ready cyc %0d: got %b, want %b", cyc, in_ready, exp_rdy);
         end
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_d || out_tag !== prev_t) begin
               errors++;
               $display("FAIL bp stall hold cyc %0d: valid=%b data=%h tag=%h, want 1/%h/%h",
                        cyc, out_valid, out_data, out_tag, prev_d, prev_t);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (out_data !== exp_d[rcv] || out_tag !== drv_t[rcv]) begin
               errors++;
               $display("FAIL bp beat %0d: data=%h tag=%h, want data=%h tag=%h",
                        rcv, out_data, out_tag, exp_d[rcv], drv_t[rcv]);
            end
            rcv++;
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
         prev_t     = out_tag;
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (rcv != 8) begin
         errors++;
         $display("FAIL bp timeout: received %0d beats, want 8", rcv);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp duplicate: out_valid=%b after drain, want 0", out_valid);
         end
      end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_mode   = M_BYP;
      in_data   = 8'h11;
      in_tag    = 4'h1;
      tick();
      in_data   = 8'h22;
      in_tag    = 4'h2;
      tick();
      in_valid  = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h11) begin
         errors++;
         $display("FAIL mid full: in_ready=%b out_valid=%b data=%h, want 0/1/11",
                  in_ready, out_valid, out_data);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL mid reset: out_valid=%b data=%h, want 0/00", out_valid, out_data);
      end
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid stale cyc %0d: out_valid=%b, want 0", i, out_valid);
         end
      end
   endtask

`ifdef ACT_LUT_SAT_CNT_EN
   task automatic test_sat_count();
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      checks++;
      if (sat_count !== 16'd0) begin
         errors++;
         $display("FAIL sat pre-clear: got %0d, want 0", sat_count);
      end
      set_beat(0, M_TANH, 8'h64, 4'h1, 8'h7F);  // clamped
      set_beat(1, M_TANH, 8'h9C, 4'h2, 8'h81);  // clamped
      set_beat(2, M_TANH, 8'h30, 4'h3, 8'h7F);  // clamped
      set_beat(3, M_RELU, 8'h64, 4'h4, 8'h7F);  // clamped index, not counted
      set_beat(4, M_TANH, 8'h01, 4'h5, 8'h0F);
      set_beat(5, M_SIG,  8'h02, 4'h6, 8'h47);
      run_stream(6);
      checks++;
      if (sat_count !== 16'd3) begin
         errors++;
         $display("FAIL sat count: got %0d, want 3", sat_count);
      end
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      checks++;
      if (sat_count !== 16'd0) begin
         errors++;
         $display("FAIL sat clear: got %0d, want 0", sat_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_tanh();
      test_sigmoid();
      test_relu_bypass();
      test_boundary();
      test_backpressure();
      test_reset_midstream();
`ifdef ACT_LUT_SAT_CNT_EN
      test_sat_count();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
